// File: rtl/sprdma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sprdma_pkg                                                      |
// | Brief    : CPU bus address constants and sprite-DMA FSM state encoding.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package sprdma_pkg;

    localparam logic [15:0] c_ppu_oamdata = 16'h2004;
    localparam logic [15:0] c_oam_dma     = 16'h4014;

    localparam int c_state_w = 3;
    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_start   = 3'd1;
    localparam state_t c_st_read    = 3'd2;
    localparam state_t c_st_capture = 3'd3;
    localparam state_t c_st_write   = 3'd4;
    localparam state_t c_st_done    = 3'd5;

endpackage : sprdma_pkg
`default_nettype wire

// File: rtl/sprdma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sprdma                                                          |
// | Brief    : Sprite (OAM) DMA: snoops a CPU write to the trigger address,    |
// |            stalls the CPU and copies one 256-byte page to OAMDATA.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sprdma
    import sprdma_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = c_oam_dma,
    parameter logic [15:0] DEST_ADDR = c_ppu_oamdata,
    parameter int          LEN       = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_r_nw,
    input  logic        dbg_ready,
    input  logic [7:0]  bus_din,
    output logic        cpu_ready,
    output logic        dma_active,
    output logic [15:0] dma_a,
    output logic        dma_r_nw,
    output logic [7:0]  dma_dout,
    output logic        dma_done
);

    localparam logic [7:0] c_last_idx = 8'(LEN - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_data_q;
    logic       r_trig_q;
    logic       w_trig;
    logic       w_launch;

    assign w_trig   = (cpu_a == TRIG_ADDR) & ~cpu_r_nw & dbg_ready;
    assign w_launch = w_trig & ~r_trig_q & (r_state == c_st_idle);

    // A debugger break sends any in-flight byte back to READ so it is re-fetched
    // and re-written once the bus is returned.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:    if (w_launch) w_next = c_st_start;
            c_st_start:   if (dbg_ready) w_next = c_st_read;
            c_st_read:    if (dbg_ready) w_next = c_st_capture;
            c_st_capture: w_next = dbg_ready ? c_st_write : c_st_read;
            c_st_write: begin
                if (!dbg_ready)              w_next = c_st_read;
                else if (r_idx == c_last_idx) w_next = c_st_done;
                else                          w_next = c_st_read;
            end
            c_st_done:    w_next = c_st_idle;
            default:      w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_data_q <= 8'h00;
            r_trig_q <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_trig_q <= w_trig;
            if (w_launch) begin
                r_page <= cpu_dout;
                r_idx  <= 8'h00;
            end
            if (r_state == c_st_capture && dbg_ready) begin
                r_data_q <= bus_din;
            end
            // Wraps FF->00, leaving the index cleared for the next transfer.
            if (r_state == c_st_write && dbg_ready) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    always_comb begin
        dma_a = 16'h0000;
        case (r_state)
            c_st_read, c_st_capture: dma_a = {r_page, r_idx};
            c_st_write:              dma_a = DEST_ADDR;
            default:                 dma_a = 16'h0000;
        endcase
    end

    assign dma_active = (r_state == c_st_start) || (r_state == c_st_read) ||
                        (r_state == c_st_capture) || (r_state == c_st_write);
    assign dma_r_nw   = ~((r_state == c_st_write) & dbg_ready);
    assign dma_dout   = r_data_q;
    assign dma_done   = (r_state == c_st_done);
    assign cpu_ready  = dbg_ready & ~dma_active;

endmodule : sprdma
`default_nettype wire

// File: tb/tb_sprdma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sprdma                                                       |
// | Brief    : Directed self-checking bench for the sprite DMA controller.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sprdma;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_r_nw;
    logic        dbg_ready;
    logic [7:0]  bus_din;
    logic        cpu_ready;
    logic        dma_active;
    logic [15:0] dma_a;
    logic        dma_r_nw;
    logic [7:0]  dma_dout;
    logic        dma_done;

    logic [7:0]  mem [0:2047];
    logic [15:0] wr_a [0:511];
    logic [7:0]  wr_d [0:511];
    int          wr_n;
    int          bad_wr;
    int          done_cnt;
    logic [15:0] last_rd;
    int          n_chk;
    int          n_err;

    sprdma dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_a     (cpu_a),
        .cpu_dout  (cpu_dout),
        .cpu_r_nw  (cpu_r_nw),
        .dbg_ready (dbg_ready),
        .bus_din   (bus_din),
        .cpu_ready (cpu_ready),
        .dma_active(dma_active),
        .dma_a     (dma_a),
        .dma_r_nw  (dma_r_nw),
        .dma_dout  (dma_dout),
        .dma_done  (dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: data for the address presented this cycle appears next cycle.
    always @(posedge clk) bus_din <= mem[dma_a[10:0]];

    always @(posedge clk) begin
        if (dma_active && dbg_ready && !dma_r_nw) begin
            wr_a[wr_n] = dma_a;
            wr_d[wr_n] = dma_dout;
            if (wr_n < 511) wr_n++;
        end
        if (!dma_r_nw && (!dbg_ready || !dma_active || dma_a != 16'h2004)) bad_wr++;
        if (dma_done) done_cnt++;
        if (dma_active && dma_r_nw && dma_a[15:8] != 8'h00) last_rd = dma_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_a    = 16'h0000;
        cpu_dout = 8'h00;
        cpu_r_nw = 1'b1;
    endtask

    task automatic check_data(input string tag, input logic [7:0] key);
        int bad;
        logic [7:0] exp;
        bad = 0;
        chk({tag, "_count"}, wr_n, 256);
        for (int i = 0; i < wr_n; i++) begin
            exp = 8'(i) ^ key;
            if (wr_a[i] !== 16'h2004 || wr_d[i] !== exp) bad++;
        end
        chk({tag, "_data_bad"}, bad, 0);
    endtask

    // Launches a transfer from page pg and runs until dma_done (bounded).
    task automatic xfer(input logic [7:0] pg, input int hold, input bit ign,
                        input bit pause, output int cyc);
        bit          got;
        bit          paused;
        int          pbad;
        logic [15:0] prev;
        wr_n     = 0;
        cpu_a    = 16'h4014;
        cpu_dout = pg;
        cpu_r_nw = 1'b0;
        cyc = 0; got = 0; paused = 0; prev = 16'h0000;
        while (!got && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
            if (cyc == hold) cpu_idle();
            if (ign && cyc == 100) begin
                cpu_a = 16'h4014; cpu_dout = 8'h03; cpu_r_nw = 1'b0;
            end
            if (ign && cyc == 101) cpu_idle();
            if (pause && !paused && dma_a == 16'h0240 && prev == 16'h0240) begin
                paused    = 1;
                dbg_ready = 1'b0;
                pbad      = 0;
                repeat (50) begin
                    @(posedge clk); #1; cyc++;
                    if (dma_r_nw !== 1'b1 || dma_active !== 1'b1 || cpu_ready !== 1'b0) pbad++;
                end
                chk("pause_hold", pbad, 0);
                dbg_ready = 1'b1;
                chk("resume_addr", dma_a, 16'h0240);
                chk("resume_rnw", dma_r_nw, 1'b1);
            end
            prev = dma_a;
            if (dma_done) got = 1;
        end
        chk("done_seen", got, 1'b1);
    endtask

    initial begin
        int cyc;
        int d0;
        int bad;
        bit hit;
        n_chk = 0; n_err = 0; wr_n = 0; bad_wr = 0; done_cnt = 0; last_rd = 16'h0000;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
            mem[16'h0300 + i] = ~8'(i);
            mem[16'h0700 + i] = 8'(i) ^ 8'hA5;
        end
        rst = 1'b1; dbg_ready = 1'b1;
        cpu_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("rst_active", dma_active, 1'b0);
        chk("rst_ready", cpu_ready, 1'b1);
        chk("rst_rnw", dma_r_nw, 1'b1);
        chk("rst_addr", dma_a, 16'h0000);
        chk("rst_dout", dma_dout, 8'h00);
        chk("rst_done", dma_done, 1'b0);
        rst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (cpu_ready !== 1'b1 || dma_active !== 1'b0 || dma_r_nw !== 1'b1) bad++;
        end
        chk("idle_bus", bad, 0);
        chk("idle_writes", wr_n, 0);

        // Held 3-cycle trigger plus an ignored retrigger with page $03.
        xfer(8'h02, 3, 1'b1, 1'b0, cyc);
        chk("x1_cycles", cyc, 770);
        chk("x1_ready_at_done", cpu_ready, 1'b1);
        chk("x1_active_at_done", dma_active, 1'b0);
        check_data("x1", 8'h5A);
        @(posedge clk); #1;
        chk("x1_done_pulse", dma_done, 1'b0);
        chk("x1_done_count", done_cnt, 1);
        repeat (5) @(posedge clk);
        #1;

        // Debugger break in CAPTURE of byte $40.
        xfer(8'h02, 1, 1'b0, 1'b1, cyc);
        check_data("x2", 8'h5A);
        repeat (5) @(posedge clk);
        #1;

        // Reset while reading byte $10.
        wr_n = 0;
        cpu_a = 16'h4014; cpu_dout = 8'h02; cpu_r_nw = 1'b0;
        @(posedge clk); #1;
        cpu_idle();
        hit = 0; cyc = 0;
        while (!hit && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
            if (dma_a == 16'h0210) hit = 1;
        end
        chk("rst_reach_idx10", hit, 1'b1);
        d0  = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_active", dma_active, 1'b0);
        chk("abort_ready", cpu_ready, 1'b1);
        chk("abort_addr", dma_a, 16'h0000);
        chk("abort_rnw", dma_r_nw, 1'b1);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        xfer(8'h02, 1, 1'b0, 1'b0, cyc);
        chk("x3_cycles", cyc, 770);
        check_data("x3", 8'h5A);
        repeat (3) @(posedge clk);
        #1;

        // Last RAM page: index wraps FF->00.
        xfer(8'h07, 1, 1'b0, 1'b0, cyc);
        chk("x4_cycles", cyc, 770);
        chk("x4_last_read", last_rd, 16'h07FF);
        check_data("x4", 8'hA5);
        @(posedge clk); #1;
        chk("x4_idle_addr", dma_a, 16'h0000);
        chk("x4_idle_active", dma_active, 1'b0);

        chk("spurious_writes", bad_wr, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_sprdma
`default_nettype wire
